arb_grant_mux: RTL and testbench

// Requester-side companion to the fixed-priority req/grant arbiter. Collects
// per-source valid/last streams, drives the arbiter req vector, samples the

---
 rtl/arb_grant_mux.sv | 120 ++++++++++++
 tb/tb_arb_grant_mux.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_grant_mux.sv
// Requester-side companion to a fixed-priority arbiter: requests, locks, muxes a packet.
// Optional sticky bad-grant flag (grant_err) enabled by ARB_GRANT_CHECK_EN.
module arb_grant_mux #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int IDX_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            s_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_REQ-1:0]            s_last,
    output logic [NUM_REQ-1:0]            s_ready,
    output logic [NUM_REQ-1:0]            arb_req,
    input  logic [NUM_REQ-1:0]            arb_grant,
    output logic                          m_valid,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_last,
    output logic [IDX_WIDTH-1:0]          m_idx,
    input  logic                          m_ready
`ifdef ARB_GRANT_CHECK_EN
    ,
    output logic                          grant_err
`endif
);

    typedef enum logic {IDLE, LOCK} state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;

    logic gnt_onehot;
    logic gnt_ok;

    function automatic logic [IDX_WIDTH-1:0] encode(input logic [NUM_REQ-1:0] v);
        logic [IDX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) r = r | IDX_WIDTH'(i);
        end
        return r;
    endfunction

    assign gnt_onehot = (arb_grant != '0) &&
                        ((arb_grant & (arb_grant - NUM_REQ'(1))) == '0);
    assign gnt_ok     = gnt_onehot && ((arb_grant & ~s_valid) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_ok) begin
                    state_d = LOCK;
                    gnt_d   = arb_grant;
                    idx_d   = encode(arb_grant);
                end
            end
            LOCK: begin
                if (m_valid && m_ready && m_last) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Requests are masked while rst_n is low so the arbiter sees nothing in reset.
    always_comb begin
        arb_req = '0;
        s_ready = '0;
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        m_idx   = '0;
        unique case (state_q)
            IDLE: begin
                arb_req = rst_n ? s_valid : '0;
            end
            LOCK: begin
                m_valid = s_valid[idx_q];
                m_data  = s_data[idx_q*DATA_WIDTH +: DATA_WIDTH];
                m_last  = s_last[idx_q];
                s_ready = gnt_q & {NUM_REQ{m_ready}};
                m_idx   = idx_q;
            end
            default: ;
        endcase
    end

`ifdef ARB_GRANT_CHECK_EN
    logic err_q, err_d;

    assign err_d = err_q |
                   ((state_q == IDLE) && (arb_grant != '0) && !gnt_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign grant_err = err_q;
`endif

endmodule

// File: tb/tb_arb_grant_mux.sv
// Scoreboard bench for arb_grant_mux: per-source packet models feed an expected-beat queue.
// Build with ARB_GRANT_CHECK_EN defined to also cover grant_err.
module tb_arb_grant_mux;

    localparam int NR = 4;
    localparam int DW = 32;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     s_valid;
    logic [NR*DW-1:0]  s_data;
    logic [NR-1:0]     s_last;
    logic [NR-1:0]     s_ready;
    logic [NR-1:0]     arb_req;
    logic [NR-1:0]     arb_grant;
    logic              m_valid;
    logic [DW-1:0]     m_data;
    logic              m_last;
    logic [1:0]        m_idx;
    logic              m_ready;
`ifdef ARB_GRANT_CHECK_EN
    logic              grant_err;
`endif

    arb_grant_mux #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .arb_req   (arb_req),
        .arb_grant (arb_grant),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_idx     (m_idx),
        .m_ready   (m_ready)
`ifdef ARB_GRANT_CHECK_EN
        ,
        .grant_err (grant_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] pkt_data [NR][8];
    int            pkt_len  [NR];
    int            pkt_pos  [NR];
    logic          gap      [NR];

    // Expected beat: {idx, last, data}
    logic [DW+2:0] exp_q [$];

    task automatic clear_src();
        for (int i = 0; i < NR; i++) begin
            pkt_len[i] = 0;
            pkt_pos[i] = 0;
            gap[i]     = 1'b0;
        end
    endtask

    task automatic load(input int src, input int len, input bit push);
        pkt_len[src] = len;
        pkt_pos[src] = 0;
        for (int b = 0; b < len; b++) begin
            pkt_data[src][b] = 32'hA000_0000 ^ (src << 12) ^ (b * 32'h0101) ^ $urandom_range(0, 255) << 20;
            if (push) exp_q.push_back({2'(src), (b == len - 1), pkt_data[src][b]});
        end
    endtask

    task automatic drive(input logic [NR-1:0] gnt, input logic rdy);
        arb_grant = gnt;
        m_ready   = rdy;
        for (int i = 0; i < NR; i++) begin
            if (pkt_pos[i] < pkt_len[i] && !gap[i]) begin
                s_valid[i]          = 1'b1;
                s_data[i*DW +: DW]  = pkt_data[i][pkt_pos[i]];
                s_last[i]           = (pkt_pos[i] == pkt_len[i] - 1);
            end else begin
                s_valid[i]          = 1'b0;
                s_data[i*DW +: DW]  = '0;
                s_last[i]           = 1'b0;
            end
        end
        #1;
    endtask

    // Scores the beat about to transfer, advances the sources, then crosses the edge.
    task automatic adv();
        logic [DW+2:0] e;
        if (m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected got=%h/%0b/%0d need=none", m_data, m_last, m_idx);
            end else begin
                e = exp_q.pop_front();
                if ({m_idx, m_last, m_data} !== e) begin
                    failures++;
                    $display("FAIL beat got idx=%0d last=%0b data=%h need idx=%0d last=%0b data=%h",
                             m_idx, m_last, m_data, e[DW+2:DW+1], e[DW], e[DW-1:0]);
                end
            end
        end
        for (int i = 0; i < NR; i++)
            if (s_valid[i] && s_ready[i]) pkt_pos[i]++;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_src();
        for (int i = 0; i < NR; i++) load(i, 1, 1'b0);
        drive(4'b0000, 1'b1);
        checks++;
        if ({arb_req, s_ready, m_valid, m_idx, m_last} !== '0 || m_data !== '0) begin
            failures++;
            $display("FAIL reset_outs got req=%b rdy=%b v=%b idx=%0d d=%h need 0",
                     arb_req, s_ready, m_valid, m_idx, m_data);
        end
        adv();
        rst_n = 1'b1;
        drive(4'b0000, 1'b1);
        checks++;
        if (arb_req !== 4'b1111) begin
            failures++;
            $display("FAIL reset_release_req got=%b need=1111", arb_req);
        end
`ifdef ARB_GRANT_CHECK_EN
        checks++;
        if (grant_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_grant_err got=%b need=0", grant_err);
        end
`endif
        clear_src();
        drive(4'b0000, 1'b0);
        adv();
    endtask

    task automatic test_basic();
        load(2, 3, 1'b1);
        drive(4'b0100, 1'b1);
        checks++;
        if (arb_req !== 4'b0100 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle got req=%b v=%b need req=0100 v=0", arb_req, m_valid);
        end
        adv();
        for (int b = 0; b < 3; b++) begin
            drive(4'b0000, 1'b1);
            checks++;
            if (m_valid !== 1'b1 || m_idx !== 2'd2 || arb_req !== 4'b0000 ||
                m_last !== (b == 2)) begin
                failures++;
                $display("FAIL basic_lock b=%0d got v=%b idx=%0d req=%b last=%b need v=1 idx=2 req=0000 last=%0b",
                         b, m_valid, m_idx, arb_req, m_last, (b == 2));
            end
            adv();
        end
        drive(4'b0000, 1'b1);
        checks++;
        if (m_valid !== 1'b0 || m_idx !== 2'd0 || s_ready !== 4'b0000) begin
            failures++;
            $display("FAIL basic_back_idle got v=%b idx=%0d rdy=%b need 0/0/0000", m_valid, m_idx, s_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] pat;
        int n;
        pat = 5'b10101;
        n = 0;
        load(2, 3, 1'b1);
        drive(4'b0100, 1'b1);
        adv();
        for (int k = 0; k < 5; k++) begin
            drive(4'b0000, pat[k]);
            checks++;
            if (s_ready !== {1'b0, pat[k], 2'b00}) begin
                failures++;
                $display("FAIL bp_s_ready k=%0d got=%b need=%b", k, s_ready, {1'b0, pat[k], 2'b00});
            end
            if (m_valid && pat[k]) n++;
            adv();
        end
        drive(4'b0000, 1'b1);
        checks++;
        if (n != 3 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_count got beats=%0d v=%b need beats=3 v=0", n, m_valid);
        end
    endtask

    task automatic test_contention();
        load(1, 2, 1'b1);
        load(3, 2, 1'b1);
        drive(4'b0010, 1'b1);
        checks++;
        if (arb_req !== 4'b1010) begin
            failures++;
            $display("FAIL cont_req got=%b need=1010", arb_req);
        end
        adv();
        for (int b = 0; b < 2; b++) begin
            drive(4'b0000, 1'b1);
            checks++;
            if (s_ready !== 4'b0010 || m_idx !== 2'd1) begin
                failures++;
                $display("FAIL cont_src1 got rdy=%b idx=%0d need rdy=0010 idx=1", s_ready, m_idx);
            end
            adv();
        end
        drive(4'b1000, 1'b1);
        checks++;
        if (m_valid !== 1'b0 || arb_req !== 4'b1000) begin
            failures++;
            $display("FAIL cont_gap got v=%b req=%b need v=0 req=1000", m_valid, arb_req);
        end
        adv();
        for (int b = 0; b < 2; b++) begin
            drive(4'b0000, 1'b1);
            checks++;
            if (m_valid !== 1'b1 || m_idx !== 2'd3) begin
                failures++;
                $display("FAIL cont_src3 got v=%b idx=%0d need v=1 idx=3", m_valid, m_idx);
            end
            adv();
        end
    endtask

    task automatic test_single_beat();
        load(0, 1, 1'b1);
        drive(4'b0001, 1'b1);
        adv();
        drive(4'b0000, 1'b1);
        checks++;
        if (m_valid !== 1'b1 || m_last !== 1'b1 || s_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_beat got v=%b last=%b rdy=%b need 1/1/0001", m_valid, m_last, s_ready);
        end
        adv();
        drive(4'b0000, 1'b1);
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 4'b0000) begin
            failures++;
            $display("FAIL single_idle got v=%b rdy=%b need 0/0000", m_valid, s_ready);
        end
    endtask

    task automatic test_valid_gap();
        load(1, 3, 1'b1);
        drive(4'b0010, 1'b1);
        adv();
        drive(4'b0000, 1'b1);
        adv();
        gap[1] = 1'b1;
        drive(4'b0000, 1'b1);
        checks++;
        if (m_valid !== 1'b0 || m_idx !== 2'd1 || s_ready !== 4'b0010 || arb_req !== 4'b0000) begin
            failures++;
            $display("FAIL gap_hold got v=%b idx=%0d rdy=%b req=%b need 0/1/0010/0000",
                     m_valid, m_idx, s_ready, arb_req);
        end
        adv();
        gap[1] = 1'b0;
        for (int b = 0; b < 2; b++) begin
            drive(4'b0000, 1'b1);
            adv();
        end
        drive(4'b0000, 1'b1);
        checks++;
        if (m_valid !== 1'b0 || m_idx !== 2'd0) begin
            failures++;
            $display("FAIL gap_done got v=%b idx=%0d need 0/0", m_valid, m_idx);
        end
    endtask

    task automatic test_bad_grant();
        load(1, 1, 1'b0);
        load(2, 1, 1'b0);
        drive(4'b0110, 1'b1);
        adv();
        drive(4'b0001, 1'b1);
        checks++;
        if (m_valid !== 1'b0 || arb_req !== 4'b0110 || s_ready !== 4'b0000) begin
            failures++;
            $display("FAIL bad_multi got v=%b req=%b rdy=%b need 0/0110/0000", m_valid, arb_req, s_ready);
        end
`ifdef ARB_GRANT_CHECK_EN
        checks++;
        if (grant_err !== 1'b1) begin
            failures++;
            $display("FAIL bad_err_set got=%b need=1", grant_err);
        end
`endif
        adv();
        drive(4'b0000, 1'b1);
        checks++;
        if (m_valid !== 1'b0 || arb_req !== 4'b0110 || m_idx !== 2'd0) begin
            failures++;
            $display("FAIL bad_unreq got v=%b req=%b idx=%0d need 0/0110/0", m_valid, arb_req, m_idx);
        end
`ifdef ARB_GRANT_CHECK_EN
        checks++;
        if (grant_err !== 1'b1) begin
            failures++;
            $display("FAIL bad_err_sticky got=%b need=1", grant_err);
        end
`endif
        adv();
        rst_n = 1'b0;
        #1;
`ifdef ARB_GRANT_CHECK_EN
        checks++;
        if (grant_err !== 1'b0) begin
            failures++;
            $display("FAIL bad_err_clear got=%b need=0", grant_err);
        end
`endif
        clear_src();
        drive(4'b0000, 1'b1);
        adv();
        rst_n = 1'b1;
    endtask

    task automatic test_mid_reset();
        load(3, 3, 1'b1);
        drive(4'b1000, 1'b1);
        adv();
        drive(4'b0000, 1'b1);
        adv();
        drive(4'b0000, 1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 4'b0000 || arb_req !== 4'b0000 || m_idx !== 2'd0) begin
            failures++;
            $display("FAIL midrst_abort got v=%b rdy=%b req=%b idx=%0d need 0/0000/0000/0",
                     m_valid, s_ready, arb_req, m_idx);
        end
        adv();
        rst_n = 1'b1;
        drive(4'b1000, 1'b1);
        checks++;
        if (arb_req !== 4'b1000 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_rereq got req=%b v=%b need 1000/0", arb_req, m_valid);
        end
        adv();
        for (int b = 0; b < 2; b++) begin
            drive(4'b0000, 1'b1);
            adv();
        end
        drive(4'b0000, 1'b1);
        checks++;
        if (m_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL midrst_done got v=%b pending=%0d need 0/0", m_valid, exp_q.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        s_valid   = '0;
        s_data    = '0;
        s_last    = '0;
        arb_grant = '0;
        m_ready   = 1'b0;
        clear_src();
        @(posedge clk);
        #2;
        test_reset();
        test_basic();
        test_backpressure();
        test_contention();
        test_single_beat();
        test_valid_gap();
        test_bad_grant();
        test_mid_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got pending=%0d need 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
